// File: rtl/data_mem_channel_arbiter_if.sv
// Requester-side and memory-side handshake bundle for the data memory channel arbiter.
// The arbiter connects through the slave modport; the requester/memory environment uses master.
interface data_mem_channel_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_CHANNELS = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32
);
    logic [NUM_REQ-1:0]                      req_valid;
    logic [NUM_REQ-1:0]                      req_write;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]      req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      req_wdata;
    logic [NUM_REQ-1:0]                      req_done;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      req_rdata;

    logic [NUM_CHANNELS-1:0]                 mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] mem_read_address;
    logic [NUM_CHANNELS-1:0]                 mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mem_read_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mem_write_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_ready;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_done, req_rdata,
        input  mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_done, req_rdata,
        output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready
    );
endinterface

// File: rtl/data_mem_channel_arbiter.sv
// Shares NUM_CHANNELS single-beat data memory channels among NUM_REQ requesters.
// Each IDLE channel grabs the next eligible requester in round-robin order every cycle.
module data_mem_channel_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_CHANNELS = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    data_mem_channel_arbiter_if.slave         arb_if,
    output logic [$clog2(NUM_CHANNELS+1)-1:0] channels_busy_o
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(NUM_CHANNELS + 1);

    typedef enum logic {IDLE, BUSY} chan_state_e;

    chan_state_e                             state_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][PTR_W-1:0]      owner_q;
    logic [NUM_CHANNELS-1:0]                 write_q;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] addr_q;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] wdata_q;
    logic [NUM_CHANNELS-1:0]                 rd_valid_q;
    logic [NUM_CHANNELS-1:0]                 wr_valid_q;
    logic [PTR_W-1:0]                        rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]                      done_q, done_d;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      rdata_q;
    logic [CNT_W-1:0]                        busy_q, busy_d;

    logic [NUM_REQ-1:0]                      owned;
    logic [NUM_CHANNELS-1:0]                 grant_valid;
    logic [NUM_CHANNELS-1:0][PTR_W-1:0]      grant_req;
    logic [NUM_CHANNELS-1:0]                 grant_write;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] grant_addr;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] grant_wdata;
    logic [NUM_CHANNELS-1:0]                 complete;
    logic [PTR_W-1:0]                        last_grant;
    logic                                    any_grant;

    // Two passes over the requesters: first those at or after rr_ptr, then the wrapped ones.
    always_comb begin : allocate
        logic [NUM_REQ-1:0] avail;
        logic               found;
        owned = '0;
        for (int c = 0; c < NUM_CHANNELS; c++)
            for (int r = 0; r < NUM_REQ; r++)
                if (state_q[c] == BUSY && owner_q[c] == PTR_W'(r)) owned[r] = 1'b1;
        avail       = arb_if.req_valid & ~owned & ~done_q;
        grant_valid = '0;
        grant_req   = '0;
        grant_write = '0;
        grant_addr  = '0;
        grant_wdata = '0;
        last_grant  = '0;
        any_grant   = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            found = 1'b0;
            if (state_q[c] == IDLE) begin
                for (int pass = 0; pass < 2; pass++)
                    for (int r = 0; r < NUM_REQ; r++)
                        if (!found && avail[r] && ((pass == 0) == (PTR_W'(r) >= rr_ptr_q))) begin
                            found          = 1'b1;
                            avail[r]       = 1'b0;
                            grant_valid[c] = 1'b1;
                            grant_req[c]   = PTR_W'(r);
                            grant_write[c] = arb_if.req_write[r];
                            grant_addr[c]  = arb_if.req_addr[r];
                            grant_wdata[c] = arb_if.req_wdata[r];
                            last_grant     = PTR_W'(r);
                            any_grant      = 1'b1;
                        end
            end
        end
    end

    // Only the ready of the direction a BUSY channel is driving can finish it.
    always_comb begin
        complete = '0;
        done_d   = '0;
        busy_d   = '0;
        rr_ptr_d = rr_ptr_q;
        if (any_grant)
            rr_ptr_d = (last_grant == PTR_W'(NUM_REQ - 1)) ? '0 : last_grant + 1'b1;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            complete[c] = (state_q[c] == BUSY) &&
                          (write_q[c] ? arb_if.mem_write_ready[c] : arb_if.mem_read_ready[c]);
            if ((state_q[c] == BUSY && !complete[c]) || (state_q[c] == IDLE && grant_valid[c]))
                busy_d = busy_d + 1'b1;
            for (int r = 0; r < NUM_REQ; r++)
                if (complete[c] && owner_q[c] == PTR_W'(r)) done_d[r] = 1'b1;
        end
    end

    // Per-channel IDLE/BUSY machine; valids are flops so they drop the cycle after ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) state_q[c] <= IDLE;
            owner_q    <= '0;
            write_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_valid_q <= '0;
            wr_valid_q <= '0;
            rr_ptr_q   <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            busy_q     <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state_q[c])
                    IDLE: begin
                        if (grant_valid[c]) begin
                            state_q[c]    <= BUSY;
                            owner_q[c]    <= grant_req[c];
                            write_q[c]    <= grant_write[c];
                            addr_q[c]     <= grant_addr[c];
                            wdata_q[c]    <= grant_wdata[c];
                            rd_valid_q[c] <= !grant_write[c];
                            wr_valid_q[c] <= grant_write[c];
                        end
                    end
                    BUSY: begin
                        if (complete[c]) begin
                            state_q[c]    <= IDLE;
                            rd_valid_q[c] <= 1'b0;
                            wr_valid_q[c] <= 1'b0;
                            for (int r = 0; r < NUM_REQ; r++)
                                if (!write_q[c] && owner_q[c] == PTR_W'(r))
                                    rdata_q[r] <= arb_if.mem_read_data[c];
                        end
                    end
                    default: state_q[c] <= IDLE;
                endcase
            end
            rr_ptr_q <= rr_ptr_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign arb_if.req_done          = done_q;
    assign arb_if.req_rdata         = rdata_q;
    assign arb_if.mem_read_valid    = rd_valid_q;
    assign arb_if.mem_write_valid   = wr_valid_q;
    assign arb_if.mem_read_address  = addr_q;
    assign arb_if.mem_write_address = addr_q;
    assign arb_if.mem_write_data    = wdata_q;
    assign channels_busy_o          = busy_q;
endmodule

// File: tb/tb_data_mem_channel_arbiter.sv
// Directed bench for the data memory channel arbiter: a 4x2 instance for the main
// scenarios and a 1x1 instance for serial back-to-back reads.
module tb_data_mem_channel_arbiter;
    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] busyA;
    logic [0:0] busyB;
    int         checkCount = 0;
    int         errorCount = 0;

    data_mem_channel_arbiter_if #(.NUM_REQ(4), .NUM_CHANNELS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) busA ();
    data_mem_channel_arbiter_if #(.NUM_REQ(1), .NUM_CHANNELS(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) busB ();

    data_mem_channel_arbiter #(.NUM_REQ(4), .NUM_CHANNELS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dutA (
        .clk(clk), .reset(reset), .arb_if(busA), .channels_busy_o(busyA)
    );

    data_mem_channel_arbiter #(.NUM_REQ(1), .NUM_CHANNELS(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dutB (
        .clk(clk), .reset(reset), .arb_if(busB), .channels_busy_o(busyB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int r, input logic valid, input logic write,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        busA.req_valid[r] = valid;
        busA.req_write[r] = write;
        busA.req_addr[r]  = addr;
        busA.req_wdata[r] = wdata;
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        busA.req_valid = '0; busA.req_write = '0; busA.req_addr = '0; busA.req_wdata = '0;
        busA.mem_read_ready = '0; busA.mem_read_data = '0; busA.mem_write_ready = '0;
        busB.req_valid = '0; busB.req_write = '0; busB.req_addr = '0; busB.req_wdata = '0;
        busB.mem_read_ready = '0; busB.mem_read_data = '0; busB.mem_write_ready = '0;
        repeat (3) tick();

        checkOutput("rst_done",   busA.req_done, 0);
        checkOutput("rst_rvalid", busA.mem_read_valid, 0);
        checkOutput("rst_wvalid", busA.mem_write_valid, 0);
        checkOutput("rst_busy",   busyA, 0);
        checkOutput("rst_raddr0", busA.mem_read_address[0], 0);
        reset = 1'b0;
        tick();

        // single read: request in c0, valid c1, ready c2, done c3
        applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        checkOutput("rd_valid_c1", busA.mem_read_valid, 2'b01);
        checkOutput("rd_addr_c1",  busA.mem_read_address[0], 32'h40);
        checkOutput("rd_wvalid_c1", busA.mem_write_valid, 2'b00);
        checkOutput("rd_busy_c1",  busyA, 1);
        tick();
        checkOutput("rd_valid_c2", busA.mem_read_valid, 2'b01);
        checkOutput("rd_done_c2",  busA.req_done, 4'b0000);
        busA.mem_read_ready = 2'b01;
        busA.mem_read_data[0] = 32'hDEADBEEF;
        tick();
        busA.mem_read_ready = 2'b00;
        checkOutput("rd_done_c3",  busA.req_done, 4'b0001);
        checkOutput("rd_rdata_c3", busA.req_rdata[0], 32'hDEADBEEF);
        checkOutput("rd_valid_c3", busA.mem_read_valid, 2'b00);
        checkOutput("rd_busy_c3",  busyA, 0);
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("rd_done_c4",  busA.req_done, 4'b0000);

        // reset in the middle of a write that would otherwise complete
        applyStimulus(1, 1'b1, 1'b1, 32'h99, 32'h55);
        tick();
        checkOutput("abort_wvalid", busA.mem_write_valid, 2'b01);
        checkOutput("abort_waddr",  busA.mem_write_address[0], 32'h99);
        checkOutput("abort_wdata",  busA.mem_write_data[0], 32'h55);
        busA.mem_write_ready = 2'b01;
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_wvalid_rst", busA.mem_write_valid, 2'b00);
        checkOutput("abort_done_rst",   busA.req_done, 4'b0000);
        checkOutput("abort_busy_rst",   busyA, 0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        busA.mem_write_ready = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("abort_done_after", busA.req_done, 4'b0000);
        checkOutput("abort_wvalid_after", busA.mem_write_valid, 2'b00);

        // four simultaneous reads with ready held high
        for (int r = 0; r < 4; r++) applyStimulus(r, 1'b1, 1'b0, 32'h100 + 32'(r * 16), 32'h0);
        busA.mem_read_ready = 2'b11;
        busA.mem_read_data[0] = 32'h1111_0000;
        busA.mem_read_data[1] = 32'h2222_0000;
        tick();
        checkOutput("four_rvalid_c1", busA.mem_read_valid, 2'b11);
        checkOutput("four_addr0_c1",  busA.mem_read_address[0], 32'h100);
        checkOutput("four_addr1_c1",  busA.mem_read_address[1], 32'h110);
        checkOutput("four_busy_c1",   busyA, 2);
        tick();
        checkOutput("four_done_c2",   busA.req_done, 4'b0011);
        checkOutput("four_rdata0_c2", busA.req_rdata[0], 32'h1111_0000);
        checkOutput("four_rdata1_c2", busA.req_rdata[1], 32'h2222_0000);
        checkOutput("four_rvalid_c2", busA.mem_read_valid, 2'b00);
        checkOutput("four_busy_c2",   busyA, 0);
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("four_rvalid_c3", busA.mem_read_valid, 2'b11);
        checkOutput("four_addr0_c3",  busA.mem_read_address[0], 32'h120);
        checkOutput("four_addr1_c3",  busA.mem_read_address[1], 32'h130);
        checkOutput("four_done_c3",   busA.req_done, 4'b0000);
        checkOutput("four_busy_c3",   busyA, 2);
        tick();
        checkOutput("four_done_c4",   busA.req_done, 4'b1100);
        checkOutput("four_rdata2_c4", busA.req_rdata[2], 32'h1111_0000);
        checkOutput("four_rdata3_c4", busA.req_rdata[3], 32'h2222_0000);
        applyStimulus(2, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(3, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("four_done_c5", busA.req_done, 4'b0000);
        checkOutput("four_busy_c5", busyA, 0);

        // fairness: ch1 stalled by r1, r0 keeps requesting, r3 must still get ch0
        busA.mem_read_ready = 2'b01;
        applyStimulus(0, 1'b1, 1'b0, 32'h200, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h210, 32'h0);
        tick();
        checkOutput("fair_addr0_c1", busA.mem_read_address[0], 32'h200);
        checkOutput("fair_addr1_c1", busA.mem_read_address[1], 32'h210);
        applyStimulus(3, 1'b1, 1'b0, 32'h230, 32'h0);
        tick();
        checkOutput("fair_done_c2",   busA.req_done, 4'b0001);
        checkOutput("fair_rvalid_c2", busA.mem_read_valid, 2'b10);
        checkOutput("fair_busy_c2",   busyA, 1);
        tick();
        checkOutput("fair_addr0_c3",  busA.mem_read_address[0], 32'h230);
        checkOutput("fair_rvalid_c3", busA.mem_read_valid, 2'b11);
        tick();
        checkOutput("fair_done_c4", busA.req_done, 4'b1000);
        applyStimulus(3, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("fair_addr0_c5",  busA.mem_read_address[0], 32'h200);
        checkOutput("fair_rvalid_c5", busA.mem_read_valid, 2'b11);
        busA.mem_read_ready = 2'b11;
        tick();
        checkOutput("fair_done_c6", busA.req_done, 4'b0011);
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        busA.mem_read_ready = 2'b00;
        tick();
        checkOutput("fair_done_c7", busA.req_done, 4'b0000);
        checkOutput("fair_busy_c7", busyA, 0);

        // write stall: r2 lands on ch0; stray readies on the wrong direction/channel are ignored
        applyStimulus(2, 1'b1, 1'b1, 32'h80, 32'h1234);
        busA.mem_read_ready  = 2'b01;
        busA.mem_write_ready = 2'b10;
        tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_wvalid", busA.mem_write_valid, 2'b01);
            checkOutput("stall_rvalid", busA.mem_read_valid, 2'b00);
            checkOutput("stall_waddr",  busA.mem_write_address[0], 32'h80);
            checkOutput("stall_wdata",  busA.mem_write_data[0], 32'h1234);
            checkOutput("stall_done",   busA.req_done, 4'b0000);
            tick();
        end
        checkOutput("stall_wvalid_end", busA.mem_write_valid, 2'b01);
        busA.mem_read_ready  = 2'b00;
        busA.mem_write_ready = 2'b01;
        tick();
        checkOutput("stall_done_after", busA.req_done, 4'b0100);
        checkOutput("stall_wvalid_after", busA.mem_write_valid, 2'b00);
        checkOutput("stall_busy_after", busyA, 0);
        applyStimulus(2, 1'b0, 1'b0, 32'h0, 32'h0);
        busA.mem_write_ready = 2'b00;
        tick();
        checkOutput("stall_done_clear", busA.req_done, 4'b0000);

        // single-channel single-requester: two reads serialised by the done cycle
        busB.req_valid = 1'b1;
        busB.req_addr[0] = 32'h10;
        busB.mem_read_ready = 1'b1;
        busB.mem_read_data[0] = 32'hCAFE0001;
        tick();
        checkOutput("one_rvalid_c1", busB.mem_read_valid, 1);
        checkOutput("one_busy_c1",   busyB, 1);
        tick();
        checkOutput("one_done_c2",   busB.req_done, 1);
        checkOutput("one_rdata_c2",  busB.req_rdata[0], 32'hCAFE0001);
        checkOutput("one_rvalid_c2", busB.mem_read_valid, 0);
        checkOutput("one_busy_c2",   busyB, 0);
        busB.req_addr[0] = 32'h14;
        busB.mem_read_data[0] = 32'hCAFE0002;
        tick();
        checkOutput("one_rvalid_c3", busB.mem_read_valid, 0);
        checkOutput("one_done_c3",   busB.req_done, 0);
        checkOutput("one_busy_c3",   busyB, 0);
        tick();
        checkOutput("one_rvalid_c4", busB.mem_read_valid, 1);
        checkOutput("one_addr_c4",   busB.mem_read_address[0], 32'h14);
        checkOutput("one_busy_c4",   busyB, 1);
        tick();
        checkOutput("one_done_c5",   busB.req_done, 1);
        checkOutput("one_rdata_c5",  busB.req_rdata[0], 32'hCAFE0002);
        checkOutput("one_busy_c5",   busyB, 0);
        busB.req_valid = 1'b0;
        busB.mem_read_ready = 1'b0;
        tick();
        checkOutput("one_done_c6", busB.req_done, 0);
        checkOutput("one_busy_c6", busyB, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
